// File: rtl/nonce_scan_pkg.sv
// Shared types and constants for the nonce result scanner: FSM states,
// the initial "no best yet" hash value and the write-back result word layout.
package nonce_scan_pkg;

  typedef enum logic [2:0] {
    IDLE,
    READ,
    FIN,
    WB0,
    WB1
  } scan_state_e;

  localparam logic [31:0] H0_INIT = 32'hFFFF_FFFF;

  localparam int FOUND_BIT = 31;

endpackage

// File: rtl/hash_min_tracker.sv
// Registered running minimum of a stream of 32-bit hashes with their indices.
// Strict compare, so the earliest index wins a tie; clear restores H0_INIT.
module hash_min_tracker
  import nonce_scan_pkg::*;
#(
  parameter int IDX_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             valid,
  input  logic [31:0]      value,
  input  logic [IDX_W-1:0] index,
  output logic [31:0]      best_value,
  output logic [IDX_W-1:0] best_index
);

  logic [31:0]      best_value_q, best_value_d;
  logic [IDX_W-1:0] best_index_q, best_index_d;

  always_comb begin
    best_value_d = best_value_q;
    best_index_d = best_index_q;
    if (clear) begin
      best_value_d = H0_INIT;
      best_index_d = '0;
    end else if (valid && (value < best_value_q)) begin
      best_value_d = value;
      best_index_d = index;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      best_value_q <= H0_INIT;
      best_index_q <= '0;
    end else begin
      best_value_q <= best_value_d;
      best_index_q <= best_index_d;
    end
  end

  assign best_value = best_value_q;
  assign best_index = best_index_q;

endmodule

// File: rtl/nonce_result_scanner.sv
// Scans NUM_NONCES H0 words from shared memory, reports the minimum and whether it beats target.
// Optional macro RESULT_WRITEBACK_EN adds two write cycles storing the result at result_addr.
module nonce_result_scanner
  import nonce_scan_pkg::*;
#(
  parameter int NUM_NONCES = 16,
  localparam int NONCE_W = $clog2(NUM_NONCES)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [15:0]        hash_addr,
  input  logic [15:0]        result_addr,
  input  logic [31:0]        target,
  output logic               mem_clk,
  output logic               mem_we,
  output logic [15:0]        mem_addr,
  output logic [31:0]        mem_write_data,
  input  logic [31:0]        mem_read_data,
  output logic               done,
  output logic               found,
  output logic [NONCE_W-1:0] best_nonce,
  output logic [31:0]        best_hash
);

  localparam logic [NONCE_W-1:0] LAST_IDX = NONCE_W'(NUM_NONCES - 1);

  scan_state_e        state_q, state_d;
  logic [NONCE_W-1:0] idx_q, idx_d;
  logic [15:0]        mem_addr_q, mem_addr_d;
  logic               done_q, done_d;
  logic               found_q, found_d;
  logic [31:0]        target_q, target_d;
  logic               track_clear, track_valid;
  logic               hit;

`ifdef RESULT_WRITEBACK_EN
  logic               mem_we_q, mem_we_d;
  logic [31:0]        mem_wdata_q, mem_wdata_d;
  logic [15:0]        result_addr_q, result_addr_d;
  logic [31:0]        result_word;
`else
  logic               unused_result_addr;
  assign unused_result_addr = ^result_addr;
`endif

  hash_min_tracker #(
    .IDX_W (NONCE_W)
  ) u_min_tracker (
    .clk        (clk),
    .reset      (reset),
    .clear      (track_clear),
    .valid      (track_valid),
    .value      (mem_read_data),
    .index      (idx_q),
    .best_value (best_hash),
    .best_index (best_nonce)
  );

  assign hit = (best_hash < target_q);

`ifdef RESULT_WRITEBACK_EN
  always_comb begin
    result_word            = '0;
    result_word[NONCE_W-1:0] = best_nonce;
    result_word[FOUND_BIT] = hit;
  end
`endif

  // Memory data is consumed on the edge after its address is registered, so
  // the READ state sees H0[idx_q] while presenting the next address.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    mem_addr_d  = mem_addr_q;
    done_d      = done_q;
    found_d     = found_q;
    target_d    = target_q;
    track_clear = 1'b0;
    track_valid = 1'b0;
`ifdef RESULT_WRITEBACK_EN
    mem_we_d      = mem_we_q;
    mem_wdata_d   = mem_wdata_q;
    result_addr_d = result_addr_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          mem_addr_d  = hash_addr;
          idx_d       = '0;
          done_d      = 1'b0;
          target_d    = target;
          track_clear = 1'b1;
          state_d     = READ;
`ifdef RESULT_WRITEBACK_EN
          result_addr_d = result_addr;
`endif
        end
      end
      READ: begin
        track_valid = 1'b1;
        mem_addr_d  = mem_addr_q + 16'd1;
        idx_d       = idx_q + NONCE_W'(1);
        if (idx_q == LAST_IDX) begin
          state_d = FIN;
        end
      end
      FIN: begin
        found_d = hit;
`ifdef RESULT_WRITEBACK_EN
        mem_we_d    = 1'b1;
        mem_addr_d  = result_addr_q;
        mem_wdata_d = result_word;
        state_d     = WB0;
`else
        done_d  = 1'b1;
        state_d = IDLE;
`endif
      end
`ifdef RESULT_WRITEBACK_EN
      WB0: begin
        mem_addr_d  = result_addr_q + 16'd1;
        mem_wdata_d = best_hash;
        state_d     = WB1;
      end
      WB1: begin
        mem_we_d = 1'b0;
        done_d   = 1'b1;
        state_d  = IDLE;
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      mem_addr_q <= '0;
      done_q     <= 1'b0;
      found_q    <= 1'b0;
      target_q   <= '0;
`ifdef RESULT_WRITEBACK_EN
      mem_we_q      <= 1'b0;
      mem_wdata_q   <= '0;
      result_addr_q <= '0;
`endif
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      mem_addr_q <= mem_addr_d;
      done_q     <= done_d;
      found_q    <= found_d;
      target_q   <= target_d;
`ifdef RESULT_WRITEBACK_EN
      mem_we_q      <= mem_we_d;
      mem_wdata_q   <= mem_wdata_d;
      result_addr_q <= result_addr_d;
`endif
    end
  end

  assign mem_clk  = clk;
  assign mem_addr = mem_addr_q;
  assign done     = done_q;
  assign found    = found_q;

`ifdef RESULT_WRITEBACK_EN
  assign mem_we         = mem_we_q;
  assign mem_write_data = mem_wdata_q;
`else
  assign mem_we         = 1'b0;
  assign mem_write_data = '0;
`endif

endmodule
